// File: rtl/icache_fill.sv
// Direct-mapped read-only instruction cache with a four-word line refill over the shared bus.
// Idle bus outputs are held at zero so they can be OR-combined with other masters.
module icache_fill #(
    parameter int NLINES = 16
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] rd_addr,
    input  logic        rd_req,
    output logic        rd_wait,
    output logic [31:0] rd_data,
    input  logic        inv,
    output logic [31:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam int IB = $clog2(NLINES);
    localparam int TW = 28 - IB;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_r;
    logic [NLINES-1:0] valid_r;
    logic [TW-1:0]     tag_r  [NLINES];
    logic [31:0]       data_r [NLINES][4];

    logic [TW-1:0]     fill_tag_r;
    logic [IB-1:0]     fill_index_r;
    logic [1:0]        cnt_r;
    logic              inv_pend_r;
    logic              bus_rd_r;
    logic [31:0]       bus_addr_r;

    logic [TW-1:0]     tag_s;
    logic [IB-1:0]     index_s;
    logic [1:0]        word_s;
    logic              hit_s;
    logic              capture_s;
    logic              last_s;
    logic              addr_unused;

    assign tag_s       = rd_addr[31:4+IB];
    assign index_s     = rd_addr[4+IB-1:4];
    assign word_s      = rd_addr[3:2];
    assign addr_unused = ^rd_addr[1:0];

    // Combinational lookup and fetch-side outputs.
    always_comb begin
        hit_s     = 1'b0;
        rd_data   = 32'd0;
        capture_s = 1'b0;
        last_s    = 1'b0;
        if (valid_r[index_s] && (tag_r[index_s] == tag_s)) begin
            hit_s   = 1'b1;
            rd_data = data_r[index_s][word_s];
        end else begin
            hit_s   = 1'b0;
            rd_data = 32'd0;
        end
        if ((state_r == FILL) && bus_ready) begin
            capture_s = 1'b1;
            last_s    = (cnt_r == 2'd3);
        end else begin
            capture_s = 1'b0;
            last_s    = 1'b0;
        end
        rd_wait = rd_req && (!hit_s || (state_r != IDLE));
    end

    assign bus_rd    = bus_rd_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wr    = 1'b0;
    assign bus_wdata = 32'd0;

    // Miss handling FSM: valid bits, fill bookkeeping and registered bus strobe/address.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state_r      <= IDLE;
            valid_r      <= {NLINES{1'b0}};
            fill_tag_r   <= {TW{1'b0}};
            fill_index_r <= {IB{1'b0}};
            cnt_r        <= 2'd0;
            inv_pend_r   <= 1'b0;
            bus_rd_r     <= 1'b0;
            bus_addr_r   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    inv_pend_r <= 1'b0;
                    if (inv) begin
                        valid_r <= {NLINES{1'b0}};
                    end
                    if (rd_req && !hit_s) begin
                        fill_tag_r   <= tag_s;
                        fill_index_r <= index_s;
                        cnt_r        <= 2'd0;
                        bus_rd_r     <= 1'b1;
                        bus_addr_r   <= {tag_s, index_s, 2'b00, 2'b00};
                        state_r      <= FILL;
                    end else begin
                        bus_rd_r   <= 1'b0;
                        bus_addr_r <= 32'd0;
                    end
                end
                FILL: begin
                    if (inv) begin
                        valid_r    <= {NLINES{1'b0}};
                        inv_pend_r <= 1'b1;
                    end
                    if (bus_ready) begin
                        cnt_r <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            // An invalidate seen at any point of the fill keeps the line invalid.
                            if (!(inv || inv_pend_r)) begin
                                valid_r[fill_index_r] <= 1'b1;
                            end
                            state_r    <= IDLE;
                            bus_rd_r   <= 1'b0;
                            bus_addr_r <= 32'd0;
                        end else begin
                            bus_addr_r <= {fill_tag_r, fill_index_r, cnt_r + 2'd1, 2'b00};
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    bus_rd_r   <= 1'b0;
                    bus_addr_r <= 32'd0;
                end
            endcase
        end
    end

    // Line storage: data and tags are not reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            data_r[fill_index_r][cnt_r] <= bus_rdata;
        end
        if (last_s) begin
            tag_r[fill_index_r] <= fill_tag_r;
        end
    end

endmodule
